xu_lie_seq_ctrl: RTL and testbench
==================================

Name: xu_lie_seq_ctrl

Overview:
- Controller that sequences the 10-bit rotating serial pattern generator.
- Accepts a pattern-plus-repeat-count job over a valid/ready handshake and drives the generator's synchronous load and pattern inputs.
- Tracks the generator's serial output, qualifies it with valid and first-bit strobes for a fixed number of full periods, then pulses done.
- Sits between the job source (config logic or testbench) and one generator instance.

Parameters:
PAT_W, 10, pattern width; fixed to the generator width; other values unsupported.
REP_W, 8, width of the repeat counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  job request valid
req_ready  output  1  controller can accept a job
req_pattern  input  PAT_W  pattern to load; bit PAT_W-1 is emitted first
req_reps  input  REP_W  full periods to emit; 0 = continuous until abort
abort  input  1  terminate the current job
gen_load  output  1  to generator synchronous load (active-high)
gen_pattern  output  PAT_W  to generator parallel input
gen_q  input  1  generator serial output
out_bit  output  1  qualified serial bit (= gen_q)
out_valid  output  1  out_bit is a live pattern bit
out_first  output  1  out_bit is bit PAT_W-1 of a period
busy  output  1  job in progress
done  output  1  one-cycle pulse on normal completion
err  output  1  sticky checker mismatch (see Optional Feature)

Behaviour:
- States: IDLE, LOAD, PRIME, RUN, DONE. All flops are reset asynchronously when reset=0.
- Reset values:
  - state=IDLE; pattern register 0; bit index 0; period counter 0; err=0.
  - Outputs: gen_load=1, gen_pattern=0, out_valid=0, out_first=0, busy=0, done=0.
- req_ready = (state==IDLE). It reads 1 during reset, but no handshake completes while reset=0.
- IDLE:
  - gen_load=1 with the held pattern, which freezes the generator.
  - On req_valid&&req_ready: capture req_pattern/req_reps and go to LOAD.
- LOAD (1 cycle): gen_load=1, gen_pattern=new pattern, busy=1. Go to PRIME.
- PRIME (1 cycle): gen_load=0; the generator moves pattern[PAT_W-1] to gen_q. Go to RUN.
- RUN:
  - gen_load=0, out_valid=1, out_bit=gen_q, busy=1.
  - Bit index counts 0..PAT_W-1 and wraps; out_first=1 when index==0.
  - Period counter increments at each wrap.
  - When index==PAT_W-1 and period==req_reps-1 (reps≠0): go to DONE.
- DONE (1 cycle): done=1, gen_load=1, out_valid=0, busy=0. Go to IDLE.
- Latency:
  - Handshake in cycle C0; LOAD in C1; PRIME in C2.
  - First out_valid in C3, carrying pattern[PAT_W-1].
  - Job length is exactly reps*PAT_W valid cycles, contiguous with no gaps.
- reps=0: RUN continues indefinitely. The period counter saturates and does not wrap to a terminal match.
- Abort:
  - abort=1 in LOAD/PRIME/RUN: next state is IDLE; no done pulse; out_valid=0 from the next cycle.
  - abort is ignored in IDLE and DONE.
  - If abort coincides with the terminal RUN cycle, abort wins (no done).
- req_valid while not IDLE: not accepted. The request must be held until req_ready.
- Reset mid-job: immediate return to reset values; the job is lost.

Optional Feature:
- Macro XU_LIE_SEQ_CHECK_EN.
- When defined:
  - An internal expected-pattern register loads in LOAD and rotates left by one each RUN cycle.
  - In every RUN cycle, gen_q is compared to the expected bit PAT_W-1.
  - A mismatch sets err=1; err stays set until reset.
- When undefined: err is tied to 0 and no checker logic exists.

Test Plan:
- Pattern 10'b1011001110, reps=2: out_valid for exactly 20 cycles starting C3; out_bit=1,0,1,1,0,0,1,1,1,0 twice; out_first at valid cycles 1 and 11; done one cycle after last bit.
- Back-to-back jobs with req_valid held high: second handshake in the IDLE cycle after DONE; second pattern's first bit 3 cycles later; no stale bits from job 1.
- Pattern 10'h3FF, reps=0, abort after 37 valid cycles: out_valid drops the next cycle; no done; req_ready=1 in the following cycle.
- Abort asserted in LOAD and in PRIME: zero out_valid cycles, no done, return to IDLE.
- reset pulsed low mid-RUN (pattern 10'h155, reps=3): all outputs return to reset values immediately; a new job afterwards behaves normally.
- With XU_LIE_SEQ_CHECK_EN: force gen_q inverted for one RUN cycle → err=1 and stays 1; with a correct generator, err=0 across all previous scenarios.

Source files
------------

// File: rtl/xu_lie_seq_ctrl.sv
// Job sequencer for the 10-bit rotating serial pattern generator: loads it, qualifies its output, counts periods.
// Optional gen_q self-checker enabled by defining XU_LIE_SEQ_CHECK_EN.
module xu_lie_seq_ctrl #(
  parameter int PAT_W = 10,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [PAT_W-1:0] req_pattern,
  input  logic [REP_W-1:0] req_reps,
  input  logic             abort,
  output logic             gen_load,
  output logic [PAT_W-1:0] gen_pattern,
  input  logic             gen_q,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_first,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PRIME = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [REP_W-1:0] per_q, per_d;

  logic last_bit, last_period;

  assign last_bit    = (idx_q == IDX_LAST);
  // reps==0 never matches, so a saturated period counter cannot end a continuous job
  assign last_period = (reps_q != '0) && (per_q == reps_q - REP_W'(1));

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    reps_d  = reps_q;
    idx_d   = idx_q;
    per_d   = per_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          pat_d   = req_pattern;
          reps_d  = req_reps;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        idx_d   = '0;
        per_d   = '0;
        state_d = abort ? S_IDLE : S_PRIME;
      end
      S_PRIME: state_d = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          idx_d = last_bit ? '0 : idx_q + IDX_W'(1);
          if (last_bit) begin
            per_d = (per_q == '1) ? per_q : per_q + REP_W'(1);
            if (last_period) state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      reps_q  <= '0;
      idx_q   <= '0;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      reps_q  <= reps_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
    end
  end

  // Generator is held in load outside LOAD..RUN so it stays frozen on the held pattern
  assign req_ready   = (state_q == S_IDLE);
  assign gen_load    = (state_q != S_PRIME) && (state_q != S_RUN);
  assign gen_pattern = pat_q;
  assign out_bit     = gen_q;
  assign out_valid   = (state_q == S_RUN);
  assign out_first   = (state_q == S_RUN) && (idx_q == '0);
  assign busy        = (state_q == S_LOAD) || (state_q == S_PRIME) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);

`ifdef XU_LIE_SEQ_CHECK_EN
  logic [PAT_W-1:0] exp_q, exp_d;
  logic             err_q, err_d;

  always_comb begin
    exp_d = exp_q;
    err_d = err_q;
    if (state_q == S_LOAD) begin
      exp_d = pat_q;
    end else if (state_q == S_RUN) begin
      exp_d = {exp_q[PAT_W-2:0], exp_q[PAT_W-1]};
      if (gen_q != exp_q[PAT_W-1]) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_xu_lie_seq_ctrl.sv
// Directed bench for xu_lie_seq_ctrl with a behavioural rotating generator attached.
module tb_xu_lie_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_pattern;
  logic [7:0] req_reps;
  logic       abort;
  logic       gen_load;
  logic [9:0] gen_pattern;
  logic       gen_q;
  logic       out_bit, out_valid, out_first, busy, done, err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Generator: parallel load, else shift MSB into registered output and rotate left
  logic [9:0] gsh = '0;
  logic       gq  = 1'b0;
  logic       inj = 1'b0;
  always @(posedge clk) begin
    if (gen_load) begin
      gsh <= gen_pattern;
    end else begin
      gq  <= gsh[9];
      gsh <= {gsh[8:0], gsh[9]};
    end
  end
  assign gen_q = gq ^ inj;

  xu_lie_seq_ctrl #(.PAT_W(10), .REP_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pattern(req_pattern), .req_reps(req_reps), .abort(abort),
    .gen_load(gen_load), .gen_pattern(gen_pattern), .gen_q(gen_q),
    .out_bit(out_bit), .out_valid(out_valid), .out_first(out_first),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_load"}, gen_load, 1);
    chk({tag, "_pat"}, gen_pattern, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_first"}, out_first, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Handshake from IDLE, then follow LOAD, PRIME and reps*10 bits through to DONE
  task automatic run_job(input logic [9:0] pat, input int reps_n);
    req_valid = 1'b1; req_pattern = pat; req_reps = 8'(reps_n);
    chk("job_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("load_gl", gen_load, 1);
    chk("load_gp", gen_pattern, {22'd0, pat});
    chk("load_busy", busy, 1);
    chk("load_valid", out_valid, 0);
    chk("load_ready", req_ready, 0);
    tick();
    chk("prime_gl", gen_load, 0);
    chk("prime_valid", out_valid, 0);
    chk("prime_busy", busy, 1);
    tick();
    for (int i = 0; i < reps_n * 10; i++) begin
      chk("run_valid", out_valid, 1);
      chk("run_bit", out_bit, pat[9 - (i % 10)]);
      chk("run_first", out_first, (i % 10) == 0);
      chk("run_done", done, 0);
      tick();
    end
    chk("done_pulse", done, 1);
    chk("done_valid", out_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_gl", gen_load, 1);
    tick();
    chk("after_done", done, 0);
    chk("after_ready", req_ready, 1);
  endtask

  logic [9:0] seq1;
  int vcnt, dcnt;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_pattern = '0; req_reps = '0; abort = 1'b0;
    #12;
    check_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // Scenario 1: spec example pattern, two periods
    seq1 = 10'b1011001110;
    chk("seq1_msb", seq1[9], 1);
    run_job(seq1, 2);

    // Scenario 2: back-to-back jobs with req_valid held high
    req_valid = 1'b1; req_pattern = 10'h2A5; req_reps = 8'd1;
    tick();
    req_pattern = 10'h0C3;
    chk("b2b_load_gp", gen_pattern, 10'h2A5);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("b2b_a_valid", out_valid, 1);
      chk("b2b_a_bit", out_bit, (10'h2A5 >> (9 - i)) & 1);
      chk("b2b_a_ready", req_ready, 0);
      tick();
    end
    chk("b2b_done", done, 1);
    tick();
    chk("b2b_idle_ready", req_ready, 1);
    chk("b2b_idle_valid", out_valid, 0);
    tick();
    req_valid = 1'b0;
    chk("b2b_b_load_gp", gen_pattern, 10'h0C3);
    chk("b2b_b_load_valid", out_valid, 0);
    tick();
    chk("b2b_b_prime_valid", out_valid, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("b2b_b_valid", out_valid, 1);
      chk("b2b_b_bit", out_bit, (10'h0C3 >> (9 - i)) & 1);
      chk("b2b_b_first", out_first, i == 0);
      tick();
    end
    chk("b2b_b_done", done, 1);
    tick();

    // Scenario 3: continuous job aborted after 37 valid cycles
    req_valid = 1'b1; req_pattern = 10'h3FF; req_reps = 8'd0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 37; i++) begin
      chk("cont_valid", out_valid, 1);
      chk("cont_bit", out_bit, 1);
      chk("cont_first", out_first, (i % 10) == 0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_busy", busy, 0);
    tick();
    chk("abort_ready2", req_ready, 1);
    chk("abort_done2", done, 0);

    // Scenario 3b: reps=0 must survive period-counter saturation
    req_valid = 1'b1; req_pattern = 10'h1E1; req_reps = 8'd0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    vcnt = 0; dcnt = 0;
    for (int i = 0; i < 2600; i++) begin
      if (out_valid) vcnt++;
      if (done) dcnt++;
      tick();
    end
    chk("sat_valid_cnt", vcnt, 2600);
    chk("sat_done_cnt", dcnt, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("sat_abort_ready", req_ready, 1);

    // Scenario 4: abort in LOAD, then abort in PRIME
    for (int ph = 0; ph < 2; ph++) begin
      req_valid = 1'b1; req_pattern = 10'h155; req_reps = 8'd1;
      tick();
      req_valid = 1'b0;
      if (ph == 1) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("early_abort_ready", req_ready, 1);
      chk("early_abort_busy", busy, 0);
      vcnt = 0; dcnt = 0;
      for (int i = 0; i < 6; i++) begin
        if (out_valid) vcnt++;
        if (done) dcnt++;
        tick();
      end
      chk("early_abort_valid_cnt", vcnt, 0);
      chk("early_abort_done_cnt", dcnt, 0);
    end

    // Scenario 5: reset pulsed mid-RUN, then a normal job
    req_valid = 1'b1; req_pattern = 10'h155; req_reps = 8'd3;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 12; i++) tick();
    chk("midrst_pre_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    #2 reset = 1'b1;
    tick();
    chk("midrst_idle_valid", out_valid, 0);
    run_job(10'h155, 3);

    chk("err_clean", err, 0);

`ifdef XU_LIE_SEQ_CHECK_EN
    // Scenario 6: one inverted generator bit must set the sticky error
    req_valid = 1'b1; req_pattern = 10'h0F0; req_reps = 8'd0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("inj_pre_err", err, 0);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("inj_err_set", err, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("inj_err_sticky", err, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("inj_err_idle", err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
